// File: rtl/tt_mux_pkg.sv
// Shared types and defaults for the mux selector sequencer.
package tt_mux_pkg;

    localparam int unsigned G_X            = 16;
    localparam int unsigned G_Y            = 24;
    localparam int unsigned DEF_N_UM       = G_X * G_Y;
    localparam int unsigned DEF_ADDR_W     = $clog2(DEF_N_UM);
    localparam int unsigned DEF_RST_CYC    = 4;
    localparam int unsigned DEF_GAP_CYC    = 2;
    localparam int unsigned DEF_PULSE_CYC  = 2;
    localparam int unsigned DEF_SETTLE_CYC = 4;

    typedef enum logic [2:0] {
        IDLE,
        DIS,
        RST,
        GAP,
        INC_HI,
        INC_LO,
        SETTLE
    } seq_state_e;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/tt_seq_timer.sv
// Loadable down-counter; zero is high once the loaded count has elapsed.
module tt_seq_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else if (start) begin
            cnt  <= load;
            zero <= (load == '0);
        end else if (!zero) begin
            cnt  <= cnt - W'(1);
            zero <= (cnt == W'(1));
        end
    end

endmodule

// File: rtl/tt_mux_sel_seq.sv
// Turns a "select user module N" request into the selector reset/increment/enable pin protocol.
module tt_mux_sel_seq
    import tt_mux_pkg::*;
#(
    parameter int unsigned N_UM       = DEF_N_UM,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned RST_CYC    = DEF_RST_CYC,
    parameter int unsigned GAP_CYC    = DEF_GAP_CYC,
    parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    localparam int unsigned TW = $clog2(max4(RST_CYC, GAP_CYC, PULSE_CYC, SETTLE_CYC) + 1);
    localparam logic [TW-1:0] LD_RST    = TW'(RST_CYC - 1);
    localparam logic [TW-1:0] LD_GAP    = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] LD_PULSE  = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] LD_SETTLE = TW'(SETTLE_CYC - 1);
    localparam logic [ADDR_W:0] N_UM_W  = (ADDR_W + 1)'(N_UM);

    seq_state_e        state, state_d;
    logic [ADDR_W-1:0] addr_lat, inc_cnt, inc_cnt_d, cur_addr_d;
    logic              ena_lat;
    logic              accept, in_range;
    logic              tmr_start, tmr_zero;
    logic [TW-1:0]     tmr_load;
    logic              req_ready_d, busy_d, done_d, err_d, cur_valid_d;
    logic              sel_rst_n_d, sel_inc_d, ena_d;

    tt_seq_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (tmr_start),
        .load  (tmr_load),
        .zero  (tmr_zero)
    );

    // Each timed state loads (cycles-1) on entry and leaves when the timer reaches zero.
    always_comb begin
        state_d   = state;
        inc_cnt_d = inc_cnt;
        tmr_start = 1'b0;
        tmr_load  = '0;
        accept    = (state == IDLE) && req_valid && req_ready;
        in_range  = ({1'b0, req_addr} < N_UM_W);

        case (state)
            IDLE: begin
                if (accept && in_range) begin
                    state_d   = DIS;
                    inc_cnt_d = '0;
                end
            end
            DIS: begin
                state_d   = RST;
                tmr_start = 1'b1;
                tmr_load  = LD_RST;
            end
            RST: begin
                if (tmr_zero) begin
                    state_d   = GAP;
                    tmr_start = 1'b1;
                    tmr_load  = LD_GAP;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    tmr_start = 1'b1;
                    if (addr_lat == '0) begin
                        state_d  = SETTLE;
                        tmr_load = LD_SETTLE;
                    end else begin
                        state_d  = INC_HI;
                        tmr_load = LD_PULSE;
                    end
                end
            end
            INC_HI: begin
                if (tmr_zero) begin
                    state_d   = INC_LO;
                    tmr_start = 1'b1;
                    tmr_load  = LD_PULSE;
                end
            end
            INC_LO: begin
                if (tmr_zero) begin
                    inc_cnt_d = inc_cnt + ADDR_W'(1);
                    tmr_start = 1'b1;
                    if (inc_cnt_d == addr_lat) begin
                        state_d  = SETTLE;
                        tmr_load = LD_SETTLE;
                    end else begin
                        state_d  = INC_HI;
                        tmr_load = LD_PULSE;
                    end
                end
            end
            SETTLE: begin
                if (tmr_zero) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the state being entered.
        req_ready_d = (state == IDLE) && (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state == SETTLE) && (state_d == IDLE);
        err_d       = accept && !in_range;
        sel_rst_n_d = (state_d != RST);
        sel_inc_d   = (state_d == INC_HI);
        ena_d       = ctrl_ena;
        cur_valid_d = cur_valid;
        cur_addr_d  = cur_addr;
        if (state_d == DIS) begin
            ena_d       = 1'b0;
            cur_valid_d = 1'b0;
        end else if (done_d) begin
            ena_d       = ena_lat;
            cur_valid_d = 1'b1;
            cur_addr_d  = addr_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            inc_cnt        <= '0;
            addr_lat       <= '0;
            ena_lat        <= 1'b0;
            req_ready      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            cur_addr       <= '0;
            cur_valid      <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
        end else begin
            state          <= state_d;
            inc_cnt        <= inc_cnt_d;
            if (accept && in_range) begin
                addr_lat <= req_addr;
                ena_lat  <= req_ena;
            end
            req_ready      <= req_ready_d;
            busy           <= busy_d;
            done           <= done_d;
            err            <= err_d;
            cur_addr       <= cur_addr_d;
            cur_valid      <= cur_valid_d;
            ctrl_sel_rst_n <= sel_rst_n_d;
            ctrl_sel_inc   <= sel_inc_d;
            ctrl_ena       <= ena_d;
        end
    end

endmodule

// File: tb/tb_tt_mux_sel_seq.sv
// Bench for tt_mux_sel_seq: timeline model derived from cycle offsets, directed cases, random traffic.
module tb_tt_mux_sel_seq;

    localparam int unsigned N_UM       = 384;
    localparam int unsigned ADDR_W     = 9;
    localparam int unsigned RST_CYC    = 4;
    localparam int unsigned GAP_CYC    = 2;
    localparam int unsigned PULSE_CYC  = 2;
    localparam int unsigned SETTLE_CYC = 4;
    localparam int          S0         = 2 + RST_CYC + GAP_CYC;

    logic              clk, rst, req_valid, req_ena;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready, busy, done, err, cur_valid;
    logic [ADDR_W-1:0] cur_addr;
    logic              ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;

    tt_mux_sel_seq #(
        .N_UM(N_UM), .ADDR_W(ADDR_W), .RST_CYC(RST_CYC), .GAP_CYC(GAP_CYC),
        .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ena(req_ena),
        .req_ready(req_ready), .busy(busy), .done(done), .err(err),
        .cur_addr(cur_addr), .cur_valid(cur_valid),
        .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int seq_len(input int a);
        return S0 + 2 * PULSE_CYC * a + SETTLE_CYC;
    endfunction

    // Model: outputs as a function of cycles elapsed since acceptance.
    bit exp_ready, exp_busy, exp_done, exp_err, exp_cur_valid, exp_rst_n, exp_inc, exp_ena;
    int exp_cur_addr;
    bit seq_on;
    int t, s_addr;
    bit s_ena;

    always @(posedge clk) begin
        if (rst) begin
            seq_on = 0; exp_ready = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
            exp_cur_addr = 0; exp_cur_valid = 0; exp_rst_n = 0; exp_inc = 0; exp_ena = 0;
        end else begin
            exp_done = 0;
            exp_err  = 0;
            if (!seq_on) begin
                if (exp_ready && req_valid && int'(req_addr) >= int'(N_UM)) begin
                    exp_err = 1;
                end else if (exp_ready && req_valid) begin
                    seq_on = 1; t = 0; s_addr = int'(req_addr); s_ena = req_ena;
                end else begin
                    exp_ready = 1; exp_rst_n = 1; exp_inc = 0;
                end
            end
            if (seq_on) begin
                t++;
                if (t == seq_len(s_addr)) begin
                    seq_on = 0; exp_done = 1; exp_ena = s_ena; exp_cur_addr = s_addr;
                    exp_cur_valid = 1; exp_busy = 0; exp_ready = 0; exp_rst_n = 1; exp_inc = 0;
                end else begin
                    exp_busy = 1; exp_ready = 0; exp_ena = 0; exp_cur_valid = 0;
                    exp_rst_n = !(t >= 2 && t <= 1 + int'(RST_CYC));
                    exp_inc = (t >= S0) && (t < S0 + 2 * int'(PULSE_CYC) * s_addr)
                              && (((t - S0) % (2 * int'(PULSE_CYC))) < int'(PULSE_CYC));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("err", err, exp_err);
            check("cur_addr", cur_addr, exp_cur_addr);
            check("cur_valid", cur_valid, exp_cur_valid);
            check("ctrl_sel_rst_n", ctrl_sel_rst_n, exp_rst_n);
            check("ctrl_sel_inc", ctrl_sel_inc, exp_inc);
            check("ctrl_ena", ctrl_ena, exp_ena);
        end
    end

    // Issue a request, then measure the done cycle and pulse count against literal expectations.
    task automatic do_select(input int a, input bit ena, input int exp_l, input bit hold,
                             input int next_a, output int waits);
        int k, pulses;
        bit prev;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(a);
        req_ena   = ena;
        waits = 0;
        while (req_ready !== 1'b1 && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 2000) check("accept_timeout", 32'(waits), 32'd0);
        @(negedge clk);
        if (hold) begin
            req_addr = ADDR_W'(next_a);
            req_ena  = 1'b0;
        end else begin
            req_valid = 1'b0;
        end
        check("dis_busy", busy, 1'b1);
        check("dis_ena", ctrl_ena, 1'b0);
        k = 1; pulses = 0; prev = 1'b0;
        while (done !== 1'b1 && k < 2000) begin
            if (ctrl_sel_inc && !prev) pulses++;
            prev = ctrl_sel_inc;
            @(negedge clk);
            k++;
        end
        check("done_cycle", 32'(k), 32'(exp_l));
        check("pulse_count", 32'(pulses), 32'(a));
        check("sel_cur_addr", cur_addr, 32'(a));
        check("sel_cur_valid", cur_valid, 1'b1);
        check("sel_ena", ctrl_ena, ena);
        check("done_ready_low", req_ready, 1'b0);
    endtask

    initial begin
        int w, k, pulses;
        bit prev;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_ena = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_sel_rst_n", ctrl_sel_rst_n, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", req_ready, 1'b1);
        check("idle_sel_rst_n", ctrl_sel_rst_n, 1'b1);

        do_select(0, 1'b1, 12, 1'b0, 0, w);
        do_select(5, 1'b1, 32, 1'b0, 0, w);

        // Out-of-range request
        @(negedge clk);
        req_valid = 1'b1; req_addr = ADDR_W'(400); req_ena = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("oor_err", err, 1'b1);
        check("oor_ready", req_ready, 1'b1);
        check("oor_cur_addr", cur_addr, 32'd5);
        check("oor_ena", ctrl_ena, 1'b1);
        check("oor_busy", busy, 1'b0);

        // Held request during busy is taken the cycle after done
        do_select(3, 1'b1, 24, 1'b1, 7, w);
        do_select(7, 1'b0, 40, 1'b0, 0, w);
        check("held_accept_waits", 32'(w), 32'd0);

        // Reset during the third increment pulse
        @(negedge clk);
        req_valid = 1'b1; req_addr = ADDR_W'(5); req_ena = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        k = 0; pulses = 0; prev = 1'b0;
        while (pulses < 3 && k < 200) begin
            if (ctrl_sel_inc && !prev) pulses++;
            prev = ctrl_sel_inc;
            if (pulses < 3) begin @(negedge clk); k++; end
        end
        check("third_pulse_seen", 32'(pulses), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_inc", ctrl_sel_inc, 1'b0);
        check("mid_rst_sel_rst_n", ctrl_sel_rst_n, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cur_valid", cur_valid, 1'b0);
        check("mid_rst_cur_addr", cur_addr, 32'd0);
        check("mid_rst_ready", req_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1'b1);
        do_select(2, 1'b1, 20, 1'b0, 0, w);

        do_select(383, 1'b0, 1544, 1'b0, 0, w);

        // Random traffic, including out-of-range requests and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom % 400) == 0;
            req_valid = ($urandom % 4) == 0;
            req_ena   = $urandom % 2;
            case ($urandom % 8)
                0:       req_addr = ADDR_W'(N_UM + ($urandom % (512 - N_UM)));
                1:       req_addr = '0;
                default: req_addr = ADDR_W'($urandom % 16);
            endcase
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        repeat (100) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
